// File: rtl/crossbar_arbiter.sv
// crossbar_arbiter
// Round-robin arbiter and packet sequencer in front of the 4-source,
// 4-destination CDMA router crossbar. One source at a time owns the single
// crossbar input for the length of a packet (bounded by MAX_BURST beats).
// Beats are forwarded only while the latched destination is ready.
//
// Ports:
//   clk, rst    - rising-edge clock, asynchronous active-high reset
//   req         - per-source beat pending
//   req_dest    - 2-bit destination per source, [2i+1:2i]
//   req_data    - DATA_W-bit beat per source, [DATA_W*i +: DATA_W]
//   req_last    - per-source last-beat-of-packet flag
//   dst_ready   - per-destination ready
//   gnt         - registered one-hot grant, zero when idle
//   ack         - combinational beat-accepted strobe per source
//   xbar_data   - beat to the crossbar (zero when no beat is presented)
//   xbar_sel    - destination select to the crossbar
//   xbar_valid  - a beat is presented this cycle
//   busy        - a grant is active
module crossbar_arbiter #(
  parameter int DATA_W    = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            req,
  input  logic [7:0]            req_dest,
  input  logic [4*DATA_W-1:0]   req_data,
  input  logic [3:0]            req_last,
  input  logic [3:0]            dst_ready,
  output logic [3:0]            gnt,
  output logic [3:0]            ack,
  output logic [DATA_W-1:0]     xbar_data,
  output logic [1:0]            xbar_sel,
  output logic                  xbar_valid,
  output logic                  busy
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [1:0]         win_q, win_d;
  logic [1:0]         sel_q, sel_d;
  logic [3:0]         gnt_q, gnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Round-robin scan starting at ptr_q.
  logic               found;
  logic [1:0]         pick;

  // Current-owner view of the request inputs.
  logic               cur_req;
  logic               cur_last;
  logic               cur_rdy;
  logic               beat_ok;
  logic               last_cnt;
  logic               release_now;

  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    for (int k = 0; k < 4; k++) begin
      if (!found && req[ptr_q + 2'(k)]) begin
        found = 1'b1;
        pick  = ptr_q + 2'(k);
      end
    end
  end

  always_comb begin
    cur_req  = req[win_q];
    cur_last = req_last[win_q];
    cur_rdy  = dst_ready[sel_q];
    beat_ok  = (state_q == GRANT) && cur_req && cur_rdy;
    // Burst cap: the beat accepted at count MAX_BURST-1 is the final one.
    last_cnt = (cnt_q == CNT_W'(MAX_BURST - 1));
    // Abandoned packets (req dropped) release without sending a beat.
    release_now = (state_q == GRANT) &&
                  (!cur_req || (beat_ok && (cur_last || last_cnt)));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      win_q   <= 2'd0;
      sel_q   <= 2'd0;
      gnt_q   <= 4'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          win_d   = pick;
          gnt_d   = 4'b0001 << pick;
          // Destination is frozen for the whole packet.
          sel_d   = req_dest[{pick, 1'b0} +: 2];
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_d = IDLE;
          gnt_d   = 4'd0;
          cnt_d   = '0;
          ptr_d   = win_q + 2'd1;
        end else if (beat_ok) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    busy       = (state_q == GRANT);
    gnt        = gnt_q;
    xbar_sel   = busy ? sel_q : 2'd0;
    xbar_valid = busy && cur_req;
    xbar_data  = xbar_valid ? req_data[int'(win_q) * DATA_W +: DATA_W] : '0;
    ack        = beat_ok ? gnt_q : 4'd0;
  end

endmodule

// File: doc/crossbar_arbiter.md
Name: crossbar_arbiter

Overview:
- Round-robin arbiter and sequencer for the 4-bit, 4-destination CDMA router crossbar.
- Shares the single crossbar input (data + 2-bit destination select) between four source requesters.
- Holds a grant for one packet (burst) and forwards beats only when the selected destination user is ready.
- Sits between the source-side spreading/queue stage and the crossbar. Its xbar_* outputs drive the crossbar data and select inputs directly.

Parameters:
- DATA_W, 4, beat width; must match the crossbar data width.
- MAX_BURST, 4, maximum beats per grant; must be ≥1. Forces release so no source can monopolise the crossbar.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  per-source request; bit i = source i has a beat pending.
- req_dest  input  8  destination per source; bits [2i+1:2i] for source i.
- req_data  input  4*DATA_W  beat data per source; bits [DATA_W*i +: DATA_W].
- req_last  input  4  per-source last-beat-of-packet flag.
- dst_ready  input  4  per-destination ready; bit d = user d can accept a beat.
- gnt  output  4  registered one-hot grant (all zero when idle).
- ack  output  4  combinational beat-accepted strobe per source.
- xbar_data  output  DATA_W  data to crossbar.
- xbar_sel  output  2  destination select to crossbar.
- xbar_valid  output  1  a beat is presented this cycle.
- busy  output  1  high while in GRANT state.

Behaviour:

Reset (asynchronous, immediate on rst=1):
- state=IDLE, ptr=0, beat_cnt=0.
- gnt=0, busy=0, xbar_sel=0.
- xbar_data=0, xbar_valid=0, ack=0.

State IDLE:
- If req≠0, pick the first set bit scanning ptr, ptr+1, … mod 4.
- Register gnt=onehot(winner) and latch xbar_sel=req_dest[winner]; go to GRANT.
- If req=0, stay in IDLE.

State GRANT (winner w):
- xbar_valid = req[w].
- xbar_data = req_data[w] when xbar_valid, else 0.
- The destination is latched at grant and does not change mid-packet; req_dest changes during the grant are ignored.
- A beat is accepted when xbar_valid && dst_ready[xbar_sel]. On acceptance: ack[w]=1 in the same cycle, beat_cnt increments.
- Release (next cycle: state=IDLE, gnt=0, beat_cnt=0, ptr=(w+1) mod 4) on any of:
  - (a) accepted beat with req_last[w]=1;
  - (b) accepted beat with beat_cnt==MAX_BURST-1, which forces release even without last;
  - (c) req[w]=0, i.e. the source abandoned the packet; no beat is sent.
- When dst_ready is low, the arbiter stalls indefinitely in GRANT. No beat counts and data is held.

Latency and throughput:
- Grant appears 1 cycle after req rises in IDLE; the first beat can be accepted in that same cycle.
- One mandatory idle cycle between grants.
- Best case: MAX_BURST beats per MAX_BURST+1 cycles.

Boundary conditions:
- ack only ever has the gnt bit set and is never asserted outside GRANT.
- gnt is always one-hot or zero.
- Requests arriving during GRANT wait for the next IDLE.
- Simultaneous req on all four sources is served in order ptr, ptr+1, ….
- rst asserted mid-packet aborts immediately: outputs return to reset values in the same cycle and the partial packet is dropped.
- MAX_BURST=1 gives single-beat round-robin.

Test Plan:
- Reset then req=4'b0001, dest0=2, data0=4'hA, last0=1, dst_ready=4'hF:
  - cycle 1: gnt=0001, xbar_sel=2, xbar_data=A, xbar_valid=1, ack=0001;
  - cycle 2: gnt=0, ptr=1.
- req=4'b1111 held, every beat last, all ready: grant order is src0, src1, src2, src3, src0, each separated by one idle cycle.
- Single source, 6-beat packet with last only on beat 6, MAX_BURST=4:
  - released after 4 acks;
  - re-granted after the idle cycle (sole requester);
  - remaining 2 beats complete with last.
- Granted to dest 1 with dst_ready[1]=0 for 5 cycles: xbar_valid=1, ack=0, data held, beat_cnt unchanged. dst_ready[1]=1 then gives ack in that cycle.
- Source 2 granted, drops req after 1 accepted beat: next cycle IDLE, gnt=0, ptr=3, no further xbar_valid.
- rst pulsed in the middle of a 3-beat burst: gnt, xbar_valid, ack and xbar_data go to 0 asynchronously. After release, arbitration restarts from ptr=0.
